// File: rtl/mul_product_accumulator.sv
// Sums COUNT unsigned products into one saturating frame total, then offers the total downstream.
// Latency: out_valid rises the cycle after the COUNT-th product is accepted.
// Backpressure: in_ready drops while a frame total waits in HOLD; it returns the cycle after out_ready takes it.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   clear                synchronous abort of the current frame (partial or pending)
//   in_valid/in_ready    product handshake; product is zero-extended into the accumulator
//   out_valid/out_ready  frame-total handshake
//   sum, overflow        saturated frame total and sticky "some add saturated" flag
module mul_product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned COUNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    localparam int unsigned      CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;
    logic             sticky_d;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [ACC_W:0]   add_full;
    logic             add_sat;
    logic             accept;

    // One extra bit of headroom: the carry out is exactly the saturation condition.
    // Once acc sits at max, any nonzero product carries again, so it stays pinned.
    always_comb begin
        add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
        add_sat  = add_full[ACC_W];
        acc_d    = add_sat ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
        sticky_d = sticky_q | add_sat;
    end

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign overflow  = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            // sum/overflow deliberately keep the last delivered frame.
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q    <= acc_d;
                        sticky_q <= sticky_d;
                        if (cnt_q == LAST) begin
                            state_q     <= HOLD;
                            sum_q       <= acc_d;
                            ovf_q       <= sticky_d;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always high in HOLD, so out_ready alone completes the handshake.
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        sticky_q    <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule
